bp_cac_coh_concentrator: RTL and testbench



---
 rtl/bp_cac_coh_concentrator.sv | 251 +++++++++++++++++++++++++
 tb/tb_bp_cac_coh_concentrator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cac_coh_concentrator.sv
// N:1 coherence-link concentrator: packet-atomic round-robin merge of client
// flits onto one wormhole link, and client-id steering of inbound packets.
module bp_cac_coh_concentrator #(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 64,
  parameter int len_offset_p = 0,
  parameter int len_width_p  = 4,
  parameter int cid_offset_p = 8,
  parameter int cid_width_p  = $clog2(num_in_p)
) (
  input  logic                             coh_clk_i,
  input  logic                             coh_reset_i,

  input  logic [num_in_p*flit_width_p-1:0] in_data_i,
  input  logic [num_in_p-1:0]              in_v_i,
  output logic [num_in_p-1:0]              in_ready_and_o,

  output logic [flit_width_p-1:0]          out_data_o,
  output logic                             out_v_o,
  input  logic                             out_ready_and_i,

  input  logic [flit_width_p-1:0]          ret_data_i,
  input  logic                             ret_v_i,
  output logic                             ret_ready_and_o,

  output logic [num_in_p*flit_width_p-1:0] ret_data_o,
  output logic [num_in_p-1:0]              ret_v_o,
  input  logic [num_in_p-1:0]              ret_ready_and_i,
  output logic                             ret_drop_o
);

  localparam int          idx_w_lp = $clog2(num_in_p);
  localparam int unsigned n_lp     = num_in_p;

  typedef logic [idx_w_lp-1:0]    idx_t;
  typedef logic [len_width_p-1:0] len_t;

  typedef enum logic [1:0] {O_IDLE, O_HOLD, O_BODY} o_state_e;
  typedef enum logic [1:0] {R_IDLE, R_BODY, R_DROP} r_state_e;

  // ---------------------------------------------------------------------------
  // Per-client 2-entry FIFOs; entry 0 is always the head
  // ---------------------------------------------------------------------------
  logic [flit_width_p-1:0] fifo_mem_q [num_in_p][2];
  logic [flit_width_p-1:0] fifo_mem_d [num_in_p][2];
  logic [1:0]              fifo_cnt_q [num_in_p];
  logic [1:0]              fifo_cnt_d [num_in_p];
  logic [num_in_p-1:0]     head_v;
  logic [num_in_p-1:0]     enq;
  logic [num_in_p-1:0]     deq;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_cnt_d = fifo_cnt_q;
    for (int unsigned i = 0; i < n_lp; i++) begin
      head_v[i]         = (fifo_cnt_q[i] != 2'd0);
      in_ready_and_o[i] = (fifo_cnt_q[i] != 2'd2) & ~coh_reset_i;
      enq[i]            = in_v_i[i] & in_ready_and_o[i];
      if (deq[i]) begin
        fifo_mem_d[i][0] = fifo_mem_q[i][1];
        fifo_cnt_d[i]    = fifo_cnt_q[i] - 2'd1;
      end
      // Write lands in the first free slot after any same-cycle dequeue.
      if (enq[i]) begin
        if (fifo_cnt_d[i] == 2'd0) fifo_mem_d[i][0] = in_data_i[i*flit_width_p +: flit_width_p];
        else                       fifo_mem_d[i][1] = in_data_i[i*flit_width_p +: flit_width_p];
        fifo_cnt_d[i] = fifo_cnt_d[i] + 2'd1;
      end
    end
  end

  always_ff @(posedge coh_clk_i) begin
    fifo_mem_q <= fifo_mem_d;
    if (coh_reset_i) begin
      for (int unsigned i = 0; i < n_lp; i++) fifo_cnt_q[i] <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outbound arbitration
  // ---------------------------------------------------------------------------
  o_state_e o_state_q, o_state_d;
  idx_t     rr_q, rr_d;
  idx_t     lock_q, lock_d;
  len_t     cnt_q, cnt_d;
  idx_t     win;
  logic     any_v;
  logic     found;
  idx_t     sel;
  logic     out_hs;
  len_t     hdr_len;
  logic [flit_width_p-1:0] head_data;

  always_comb begin
    win   = rr_q;
    found = 1'b0;
    any_v = |head_v;
    for (int unsigned k = 1; k <= n_lp; k++) begin
      idx_t cand;
      cand = idx_t'((32'(rr_q) + k) % n_lp);
      if (!found && head_v[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    o_state_d = o_state_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    deq       = '0;

    sel        = (o_state_q == O_IDLE) ? win : lock_q;
    head_data  = fifo_mem_q[sel][0];
    out_data_o = head_data;
    out_v_o    = (o_state_q == O_IDLE) ? any_v : head_v[sel];
    out_hs     = out_v_o & out_ready_and_i;
    hdr_len    = head_data[len_offset_p +: len_width_p];
    if (out_hs) deq[sel] = 1'b1;

    unique case (o_state_q)
      O_IDLE: begin
        if (any_v) begin
          lock_d = win;
          if (out_hs) begin
            cnt_d = hdr_len;
            if (hdr_len == '0) rr_d = win;
            else               o_state_d = O_BODY;
          end else begin
            o_state_d = O_HOLD;
          end
        end
      end
      O_HOLD: begin
        if (out_hs) begin
          cnt_d = hdr_len;
          if (hdr_len == '0) begin
            rr_d      = lock_q;
            o_state_d = O_IDLE;
          end else begin
            o_state_d = O_BODY;
          end
        end
      end
      O_BODY: begin
        if (out_hs) begin
          cnt_d = cnt_q - len_t'(1);
          if (cnt_q == len_t'(1)) begin
            rr_d      = lock_q;
            o_state_d = O_IDLE;
          end
        end
      end
      default: o_state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge coh_clk_i) begin
    if (coh_reset_i) begin
      o_state_q <= O_IDLE;
      rr_q      <= idx_t'(num_in_p - 1);
      lock_q    <= '0;
      cnt_q     <= '0;
    end else begin
      o_state_q <= o_state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Inbound steering (combinational data path)
  // ---------------------------------------------------------------------------
  r_state_e r_state_q, r_state_d;
  idx_t     r_dest_q, r_dest_d;
  len_t     r_cnt_q, r_cnt_d;
  logic [cid_width_p-1:0] ret_cid;
  len_t     ret_len;
  logic     cid_legal;
  idx_t     cid_idx;
  logic     ret_hs;

  assign ret_data_o = {num_in_p{ret_data_i}};

  always_comb begin
    r_state_d       = r_state_q;
    r_dest_d        = r_dest_q;
    r_cnt_d         = r_cnt_q;
    ret_v_o         = '0;
    ret_ready_and_o = 1'b0;
    ret_drop_o      = 1'b0;

    ret_cid   = ret_data_i[cid_offset_p +: cid_width_p];
    ret_len   = ret_data_i[len_offset_p +: len_width_p];
    cid_legal = (32'(ret_cid) < n_lp);
    cid_idx   = idx_t'(ret_cid);

    unique case (r_state_q)
      R_IDLE: begin
        if (cid_legal) begin
          ret_v_o[cid_idx] = ret_v_i;
          ret_ready_and_o  = ret_ready_and_i[cid_idx];
        end else begin
          ret_ready_and_o = 1'b1;
          ret_drop_o      = ret_v_i;
        end
        ret_hs = ret_v_i & ret_ready_and_o;
        if (ret_hs && ret_len != '0) begin
          r_cnt_d   = ret_len;
          r_dest_d  = cid_idx;
          r_state_d = cid_legal ? R_BODY : R_DROP;
        end
      end
      R_BODY, R_DROP: begin
        if (r_state_q == R_BODY) begin
          ret_v_o[r_dest_q] = ret_v_i;
          ret_ready_and_o   = ret_ready_and_i[r_dest_q];
        end else begin
          ret_ready_and_o = 1'b1;
        end
        ret_hs = ret_v_i & ret_ready_and_o;
        if (ret_hs) begin
          r_cnt_d = r_cnt_q - len_t'(1);
          if (r_cnt_q == len_t'(1)) r_state_d = R_IDLE;
        end
      end
      default: begin
        ret_hs    = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge coh_clk_i) begin
    if (coh_reset_i) begin
      r_state_q <= R_IDLE;
      r_dest_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_dest_q  <= r_dest_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_cac_coh_concentrator.sv
// Randomized bench for bp_cac_coh_concentrator against a packet-level
// queue model of the outbound merge and inbound steering.
module tb_bp_cac_coh_concentrator;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int LW = 4;
  localparam int CW = 3;
  localparam int NCYC = 4000;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_v;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic             out_v;
  logic             out_ready;
  logic [W-1:0]     ret_data;
  logic             ret_v;
  logic             ret_ready_o;
  logic [N*W-1:0]   ret_data_o;
  logic [N-1:0]     ret_v_o;
  logic [N-1:0]     ret_ready_i;
  logic             ret_drop;

  always #5 clk = ~clk;

  bp_cac_coh_concentrator #(
    .num_in_p(N), .flit_width_p(W), .len_offset_p(0), .len_width_p(LW),
    .cid_offset_p(8), .cid_width_p(CW)
  ) dut (
    .coh_clk_i(clk), .coh_reset_i(rst),
    .in_data_i(in_data), .in_v_i(in_v), .in_ready_and_o(in_ready),
    .out_data_o(out_data), .out_v_o(out_v), .out_ready_and_i(out_ready),
    .ret_data_i(ret_data), .ret_v_i(ret_v), .ret_ready_and_o(ret_ready_o),
    .ret_data_o(ret_data_o), .ret_v_o(ret_v_o), .ret_ready_and_i(ret_ready_i),
    .ret_drop_o(ret_drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model state: accepted-but-unsent flits per client, packet lock, rr pointer
  logic [W-1:0] mq    [N][$];
  logic [W-1:0] drv_q [N][$];
  logic [W-1:0] rq [$];
  int drv_gap [N];
  int rgap;
  int m_lock, m_rr, m_rem, m_body_sent;
  bit m_hdr;
  int r_st, r_dest, r_rem;

  function automatic logic [W-1:0] make_flit(input bit hdr, input int len, input int cid);
    logic [W-1:0] f;
    f = {$urandom, $urandom};
    if (hdr) begin
      f[3:0]  = 4'(len);
      f[10:8] = 3'(cid);
    end
    return f;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      drv_q[i].delete();
      drv_gap[i] = 0;
    end
    rq.delete();
    rgap = 0;
    m_lock = -1;
    m_rr = N - 1;
    m_rem = 0;
    m_hdr = 1'b1;
    m_body_sent = 0;
    r_st = 0;
    r_dest = 0;
    r_rem = 0;
  endtask

  initial begin
    bit do_reset, post_rst, did_mid_rst;
    bit exp_v, out_hs, legal, exp_rr, exp_drop, rhs;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [W-1:0] f, rd;
    int len, cid;

    rst = 1'b1; in_v = '0; in_data = '0; out_ready = 1'b0;
    ret_v = 1'b0; ret_data = '0; ret_ready_i = '0;
    do_reset = 0; post_rst = 0; did_mid_rst = 0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_out_v", out_v, 0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_ret_v", ret_v_o, 0);
    check("rst_drop", ret_drop, 0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (do_reset) begin
        rst = 1'b1; in_v = '0; ret_v = 1'b0;
        reset_model();
        do_reset = 0;
        post_rst = 1;
        continue;
      end
      rst = 1'b0;

      // Client drivers
      for (int i = 0; i < N; i++) begin
        if (drv_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(0, 3);
          drv_q[i].push_back(make_flit(1, len, i));
          for (int b = 0; b < len; b++) drv_q[i].push_back(make_flit(0, 0, 0));
        end
        if (drv_gap[i] > 0) begin
          drv_gap[i]--;
          in_v[i] = 1'b0;
        end else begin
          in_v[i] = (drv_q[i].size() != 0);
        end
        in_data[i*W +: W] = (drv_q[i].size() != 0) ? drv_q[i][0] : make_flit(0, 0, 0);
      end
      if ((cyc / 64) % 4 == 3) out_ready = ($urandom_range(0, 9) == 0);
      else                     out_ready = ($urandom_range(0, 3) != 0);

      // Inbound driver
      if (rq.size() == 0 && $urandom_range(0, 2) == 0) begin
        len = $urandom_range(0, 3);
        cid = $urandom_range(0, 5);
        rq.push_back(make_flit(1, len, cid));
        for (int b = 0; b < len; b++) rq.push_back(make_flit(0, 0, 0));
      end
      if (rgap > 0) begin
        rgap--;
        ret_v = 1'b0;
      end else begin
        ret_v = (rq.size() != 0);
      end
      ret_data = (rq.size() != 0) ? rq[0] : make_flit(0, 0, 0);
      for (int i = 0; i < N; i++) ret_ready_i[i] = ($urandom_range(0, 3) != 0);

      #1;
      if (post_rst) begin
        check("rst_mid_out_v", out_v, 0);
        check("rst_mid_in_ready", in_ready, 4'hF);
        post_rst = 0;
      end

      // Outbound: lock the round-robin winner once a packet is presented
      if (m_lock < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_lock < 0 && mq[(m_rr + k) % N].size() != 0) begin
            m_lock = (m_rr + k) % N;
            m_hdr = 1'b1;
            m_body_sent = 0;
          end
        end
      end
      exp_v = (m_lock >= 0) && (mq[m_lock].size() != 0);
      check("out_v", out_v, exp_v);
      if (exp_v) check("out_data", out_data, mq[m_lock][0]);
      for (int i = 0; i < N; i++) begin
        exp_rdy[i] = (mq[i].size() < 2);
        check($sformatf("in_ready%0d", i), in_ready[i], exp_rdy[i]);
      end

      out_hs = exp_v && out_ready;
      if (out_hs) begin
        f = mq[m_lock].pop_front();
        if (m_hdr) begin
          m_rem = int'(f[3:0]);
          m_hdr = 1'b0;
        end else begin
          m_rem--;
          m_body_sent++;
        end
        if (m_rem == 0) begin
          m_rr = m_lock;
          m_lock = -1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (in_v[i] && exp_rdy[i]) begin
          mq[i].push_back(drv_q[i].pop_front());
          drv_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        end
      end

      // Inbound expectations
      rd = ret_data;
      cid = int'(rd[10:8]);
      len = int'(rd[3:0]);
      legal = (cid < N);
      exp_rv = '0;
      exp_drop = 1'b0;
      exp_rr = 1'b1;
      if (r_st == 0) begin
        if (legal) begin
          exp_rv[cid] = ret_v;
          exp_rr = ret_ready_i[cid];
        end else begin
          exp_drop = ret_v;
        end
      end else if (r_st == 1) begin
        exp_rv[r_dest] = ret_v;
        exp_rr = ret_ready_i[r_dest];
      end
      check("ret_v_o", ret_v_o, exp_rv);
      check("ret_ready", ret_ready_o, exp_rr);
      check("ret_drop", ret_drop, exp_drop);
      check("ret_data", ret_data_o, {N{rd}});

      rhs = ret_v && exp_rr;
      if (rhs) begin
        void'(rq.pop_front());
        rgap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if (r_st == 0) begin
          if (len > 0) begin
            r_rem = len;
            r_dest = cid;
            r_st = legal ? 1 : 2;
          end
        end else begin
          r_rem--;
          if (r_rem == 0) r_st = 0;
        end
      end

      // Reset once mid-body, after the first body flit of a packet has gone
      if (cyc >= NCYC / 2 && !did_mid_rst && m_lock >= 0 && !m_hdr && m_body_sent >= 1 && m_rem >= 1) begin
        do_reset = 1;
        did_mid_rst = 1;
      end
    end

    check("mid_rst_done", did_mid_rst, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
